// File: rtl/grf_scoreboard.sv
// Issue-stage scoreboard for the 32x32 GRF: tracks in-flight writers and their
// forwarding latency, stalls decode on unready sources, retires entries by tag.
module grf_scoreboard #(
    parameter int TAG_W = 3,
    parameter int LAT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic [4:0]       issue_rt,
    input  logic             issue_use_rs,
    input  logic             issue_use_rt,
    input  logic             issue_wr,
    input  logic [4:0]       issue_rd,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             flush,
    output logic             stall,
    output logic [TAG_W-1:0] issue_tag,
    output logic [31:0]      busy_mask
);

    logic [31:0]      pend_q, pend_d;
    logic [LAT_W-1:0] timer_q [32];
    logic [LAT_W-1:0] timer_d [32];
    logic [TAG_W-1:0] tag_q   [32];
    logic [TAG_W-1:0] tag_d   [32];
    logic [TAG_W-1:0] tag_ctr_q, tag_ctr_d;

    logic rs_haz, rt_haz, accept, wr_ok, commit_ok;

    // A pending entry whose timer reached zero is served by forwarding.
    assign rs_haz = issue_use_rs && (issue_rs != 5'd0) && pend_q[issue_rs]
                    && (timer_q[issue_rs] != '0);
    assign rt_haz = issue_use_rt && (issue_rt != 5'd0) && pend_q[issue_rt]
                    && (timer_q[issue_rt] != '0);

    assign stall     = issue_valid && !flush && (rs_haz || rt_haz);
    assign accept    = issue_valid && !stall && !flush;
    assign wr_ok     = accept && issue_wr && (issue_rd != 5'd0);
    assign commit_ok = wb_valid && (wb_addr != 5'd0) && pend_q[wb_addr]
                       && (tag_q[wb_addr] == wb_tag);

    assign issue_tag = tag_ctr_q;
    assign busy_mask = pend_q;

    always_comb begin
        pend_d    = pend_q;
        tag_ctr_d = tag_ctr_q;
        for (int r = 0; r < 32; r++) begin
            timer_d[r] = timer_q[r];
            tag_d[r]   = tag_q[r];
        end

        if (flush) begin
            pend_d = '0;
            for (int r = 0; r < 32; r++) begin
                timer_d[r] = '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (pend_q[r] && (timer_q[r] != '0)) begin
                    timer_d[r] = timer_q[r] - LAT_W'(1);
                end
            end
            if (commit_ok) begin
                pend_d[wb_addr]  = 1'b0;
                timer_d[wb_addr] = '0;
            end
            // Applied after commit so a same-register issue overrides the retire.
            if (wr_ok) begin
                pend_d[issue_rd]  = 1'b1;
                timer_d[issue_rd] = issue_lat;
                tag_d[issue_rd]   = tag_ctr_q;
                tag_ctr_d         = tag_ctr_q + TAG_W'(1);
            end
        end

        pend_d[0]  = 1'b0;
        timer_d[0] = '0;
        tag_d[0]   = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q    <= '0;
            tag_ctr_q <= '0;
            for (int r = 0; r < 32; r++) begin
                timer_q[r] <= '0;
                tag_q[r]   <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            tag_ctr_q <= tag_ctr_d;
            for (int r = 0; r < 32; r++) begin
                timer_q[r] <= timer_d[r];
                tag_q[r]   <= tag_d[r];
            end
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Scenario bench for grf_scoreboard: expected busy masks are queued when stimulus
// is driven and compared after the clock edge; stall/issue_tag checked inline.
module tb_grf_scoreboard;

    localparam int TAG_W = 3;
    localparam int LAT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid, issue_use_rs, issue_use_rt, issue_wr;
    logic [4:0]       issue_rs, issue_rt, issue_rd;
    logic [LAT_W-1:0] issue_lat;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [TAG_W-1:0] wb_tag;
    logic             flush;
    logic             stall;
    logic [TAG_W-1:0] issue_tag;
    logic [31:0]      busy_mask;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    grf_scoreboard #(.TAG_W(TAG_W), .LAT_W(LAT_W)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .issue_wr(issue_wr), .issue_rd(issue_rd), .issue_lat(issue_lat),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_tag(wb_tag),
        .flush(flush), .stall(stall), .issue_tag(issue_tag), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_use_rs = 0; issue_use_rt = 0; issue_wr = 0;
        issue_rs = 0; issue_rt = 0; issue_rd = 0; issue_lat = 0;
        wb_valid = 0; wb_addr = 0; wb_tag = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        #3;
        reset = 1;
        exp_q.delete();
    endtask

    task automatic drive_write(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
        idle();
        issue_valid = 1; issue_wr = 1; issue_rd = rd; issue_lat = lat;
    endtask

    task automatic drive_read_rs(input logic [4:0] rs);
        idle();
        issue_valid = 1; issue_use_rs = 1; issue_rs = rs;
    endtask

    task automatic test_reset();
        idle();
        issue_valid = 1; issue_use_rs = 1; issue_rs = 5'd8;
        reset = 0;
        #2;
        n_tests++;
        if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_mask got %h exp %h", busy_mask, 32'h0); end
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
        n_tests++;
        if (issue_tag !== 3'd0) begin n_fail++; $display("FAIL reset_tag got %0d exp 0", issue_tag); end
        @(posedge clk);
        #1;
        reset = 1;
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_write(5'd8, 2'd2);
        #1;
        n_tests++;
        if (issue_tag !== 3'd0) begin n_fail++; $display("FAIL lu_tag got %0d exp 0", issue_tag); end
        exp_q.push_back(32'h1 << 8);
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL lu_mask0 got %h exp %h", busy_mask, e); end
        drive_read_rs(5'd8);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_t2 got %b exp 1", stall); end
        tick();
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_t1 got %b exp 1", stall); end
        tick();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_t0 got %b exp 0", stall); end
        exp_q.push_back(32'h1 << 8);
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL lu_mask_hold got %h exp %h", busy_mask, e); end
        idle();
        wb_valid = 1; wb_addr = 5'd8; wb_tag = 3'd0;
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL lu_commit got %h exp %h", busy_mask, e); end
        idle();
    endtask

    task automatic test_waw();
        do_reset();
        drive_write(5'd5, 2'd3);
        tick();
        drive_write(5'd5, 2'd0);
        #1;
        n_tests++;
        if (issue_tag !== 3'd1) begin n_fail++; $display("FAIL waw_tag got %0d exp 1", issue_tag); end
        tick();
        // Pending with timer 0 must not stall; stale commit rides along.
        drive_read_rs(5'd5);
        wb_valid = 1; wb_addr = 5'd5; wb_tag = 3'd0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_fwd_stall got %b exp 0", stall); end
        exp_q.push_back(32'h1 << 5);
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL waw_stale got %h exp %h", busy_mask, e); end
        idle();
        wb_valid = 1; wb_addr = 5'd5; wb_tag = 3'd1;
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL waw_match got %h exp %h", busy_mask, e); end
        idle();
    endtask

    task automatic test_zero();
        do_reset();
        drive_write(5'd0, 2'd3);
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL zero_mask got %h exp %h", busy_mask, e); end
        n_tests++;
        if (issue_tag !== 3'd0) begin n_fail++; $display("FAIL zero_tag got %0d exp 0", issue_tag); end
        drive_read_rs(5'd0);
        wb_valid = 1; wb_addr = 5'd0; wb_tag = 3'd0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall got %b exp 0", stall); end
        tick();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        drive_write(5'd9, 2'd3);
        tick();
        drive_read_rs(5'd9);
        issue_wr = 1; issue_rd = 5'd10; issue_lat = 2'd1;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall got %b exp 1", stall); end
        flush = 1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", stall); end
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL flush_mask got %h exp %h", busy_mask, e); end
        n_tests++;
        if (issue_tag !== 3'd1) begin n_fail++; $display("FAIL flush_tag got %0d exp 1", issue_tag); end
        idle();
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive_write(5'd7, 2'd3);
        tick();
        drive_write(5'd7, 2'd2);
        wb_valid = 1; wb_addr = 5'd7; wb_tag = 3'd0;
        exp_q.push_back(32'h1 << 7);
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL same_mask got %h exp %h", busy_mask, e); end
        n_tests++;
        if (issue_tag !== 3'd2) begin n_fail++; $display("FAIL same_tag got %0d exp 2", issue_tag); end
        // New latency 2 visible as two stall cycles, then ready.
        drive_read_rs(5'd7);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL same_stall_t2 got %b exp 1", stall); end
        tick();
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL same_stall_t1 got %b exp 1", stall); end
        tick();
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL same_stall_t0 got %b exp 0", stall); end
        // Issue r3 while committing with the old r7 tag: r3 set, r7 untouched.
        drive_write(5'd3, 2'd1);
        wb_valid = 1; wb_addr = 5'd7; wb_tag = 3'd0;
        exp_q.push_back((32'h1 << 7) | (32'h1 << 3));
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL same_old_tag got %h exp %h", busy_mask, e); end
        idle();
        wb_valid = 1; wb_addr = 5'd7; wb_tag = 3'd1;
        exp_q.push_back(32'h1 << 3);
        tick();
        e = exp_q.pop_front(); n_tests++;
        if (busy_mask !== e) begin n_fail++; $display("FAIL same_new_tag got %h exp %h", busy_mask, e); end
        idle();
    endtask

    task automatic test_tag_wrap();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive_write(5'(i + 1), 2'd0);
            #1;
            n_tests++;
            if (issue_tag !== 3'(i)) begin n_fail++; $display("FAIL wrap_tag%0d got %0d exp %0d", i, issue_tag, i % 8); end
            tick();
        end
        n_tests++;
        if (issue_tag !== 3'd1) begin n_fail++; $display("FAIL wrap_final got %0d exp 1", issue_tag); end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive_write(5'(i), 2'd3);
            tick();
        end
        idle();
        n_tests++;
        if (busy_mask !== 32'h1E) begin n_fail++; $display("FAIL ar_pre got %h exp %h", busy_mask, 32'h1E); end
        #2;
        reset = 0;
        #1;
        n_tests++;
        if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL ar_mask got %h exp %h", busy_mask, 32'h0); end
        n_tests++;
        if (issue_tag !== 3'd0) begin n_fail++; $display("FAIL ar_tag_now got %0d exp 0", issue_tag); end
        #1;
        reset = 1;
        tick();
        n_tests++;
        if (issue_tag !== 3'd0) begin n_fail++; $display("FAIL ar_tag_after got %0d exp 0", issue_tag); end
    endtask

    initial begin
        idle();
        reset = 0;
        test_reset();
        test_load_use();
        test_waw();
        test_zero();
        test_flush();
        test_same_cycle();
        test_tag_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
